// File: rtl/letter_pkg.sv
// Shared letter-code types and raster widths for the letter rendering path
// (letter_cell_sequencer, letter_buffer and draw_letter).
package letter_pkg;

  localparam int CODE_W   = 6;
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  typedef logic [CODE_W-1:0] letter_code_t;

  localparam letter_code_t BLANK_CODE = 6'd63;

  function automatic logic is_blank(input letter_code_t code);
    return code == BLANK_CODE;
  endfunction

endpackage

// File: rtl/letter_buffer.sv
// Shadow/display double buffer of letter codes: writes land in the shadow copy,
// a commit strobe copies the whole shadow into the display copy read by the raster.
module letter_buffer
  import letter_pkg::*;
#(
  parameter int NUM_CELLS = 8,
  parameter int IDX_W     = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_index_i,
  input  letter_code_t       wr_code_i,
  input  logic               commit_i,
  input  logic [IDX_W-1:0]   rd_index_i,
  output letter_code_t       rd_code_o
);

  localparam logic [IDX_W:0] NUM_CELLS_EXT = NUM_CELLS[IDX_W:0];

  letter_code_t shadow_q  [NUM_CELLS];
  letter_code_t display_q [NUM_CELLS];

  logic wr_in_range;
  logic rd_in_range;

  // Out-of-range indices only arise when NUM_CELLS is not a power of two.
  assign wr_in_range = {1'b0, wr_index_i} < NUM_CELLS_EXT;
  assign rd_in_range = {1'b0, rd_index_i} < NUM_CELLS_EXT;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        shadow_q[i]  <= BLANK_CODE;
        display_q[i] <= BLANK_CODE;
      end
    end else begin
      if (wr_en_i && wr_in_range) begin
        shadow_q[wr_index_i] <= wr_code_i;
      end
      if (commit_i) begin
        for (int i = 0; i < NUM_CELLS; i++) begin
          display_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign rd_code_o = rd_in_range ? display_q[rd_index_i] : BLANK_CODE;

endmodule

// File: rtl/letter_cell_sequencer.sv
// Raster-driven feeder for draw_letter: walks a line of NUM_CELLS letter cells and
// emits code/origin per pixel with 2-cycle latency. LETTER_SCROLL_EN adds scrolling.
module letter_cell_sequencer
  import letter_pkg::*;
#(
  parameter int WIDTH         = 119,
  parameter int HEIGHT        = 82,
  parameter int NUM_CELLS     = 8,
  parameter int ORIGIN_X      = 16,
  parameter int ORIGIN_Y      = 256,
  parameter int SCROLL_FRAMES = 30,
  parameter int CELL_W        = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                wr_valid_in,
  output logic                wr_ready_out,
  input  logic [CELL_W-1:0]   wr_index_in,
  input  letter_code_t        wr_code_in,
  output letter_code_t        select_letter_out,
  output logic [HCOUNT_W-1:0] x_out,
  output logic [VCOUNT_W-1:0] y_out,
  output logic                cell_active_out,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out
);

  localparam int PX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [PX_W-1:0]     PX_LAST   = PX_W'(WIDTH - 1);
  localparam logic [CELL_W-1:0]   CELL_LAST = CELL_W'(NUM_CELLS - 1);
  localparam logic [HCOUNT_W-1:0] X_START   = HCOUNT_W'(ORIGIN_X);
  localparam logic [HCOUNT_W-1:0] X_STEP    = HCOUNT_W'(WIDTH);
  localparam logic [VCOUNT_W-1:0] Y_TOP     = VCOUNT_W'(ORIGIN_Y);
  localparam logic [VCOUNT_W-1:0] Y_BOT     = VCOUNT_W'(ORIGIN_Y + HEIGHT - 1);

  logic commit;
  logic wr_fire;
  logic row_hit;
  logic start_hit;
  logic h_contig;

  logic                active_q, active_d;
  logic [PX_W-1:0]     px_cnt_q, px_cnt_d;
  logic [CELL_W-1:0]   cell_q,   cell_d;
  logic [HCOUNT_W-1:0] x_acc_q,  x_acc_d;
  logic [HCOUNT_W-1:0] h1_q;
  logic [VCOUNT_W-1:0] v1_q;

  logic [CELL_W-1:0] rd_index;
  letter_code_t      rd_code;

  assign commit       = (hcount_in == '0) && (vcount_in == '0);
  // Refusing writes on the commit cycle keeps the shadow stable while it is copied.
  assign wr_ready_out = rst_in && !commit;
  assign wr_fire      = wr_valid_in && wr_ready_out;

  assign row_hit   = (vcount_in >= Y_TOP) && (vcount_in <= Y_BOT);
  assign start_hit = (hcount_in == X_START) && row_hit;
  assign h_contig  = (hcount_in == h1_q + HCOUNT_W'(1));

  letter_buffer #(
    .NUM_CELLS (NUM_CELLS),
    .IDX_W     (CELL_W)
  ) u_buffer (
    .clk_i      (pixel_clk_in),
    .rst_ni     (rst_in),
    .wr_en_i    (wr_fire),
    .wr_index_i (wr_index_in),
    .wr_code_i  (wr_code_in),
    .commit_i   (commit),
    .rd_index_i (rd_index),
    .rd_code_o  (rd_code)
  );

`ifdef LETTER_SCROLL_EN
  localparam int FR_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [FR_W-1:0]   FR_LAST       = FR_W'(SCROLL_FRAMES - 1);
  localparam logic [CELL_W:0]   NUM_CELLS_EXT = NUM_CELLS[CELL_W:0];

  logic [FR_W-1:0]   frame_q;
  logic [CELL_W-1:0] scroll_q;
  logic [CELL_W:0]   rd_sum;

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      frame_q  <= '0;
      scroll_q <= '0;
    end else if (commit) begin
      if (frame_q == FR_LAST) begin
        frame_q  <= '0;
        scroll_q <= (scroll_q == CELL_LAST) ? '0 : scroll_q + CELL_W'(1);
      end else begin
        frame_q <= frame_q + FR_W'(1);
      end
    end
  end

  // Both operands are below NUM_CELLS, so one conditional subtract is a full modulo.
  assign rd_sum   = {1'b0, cell_q} + {1'b0, scroll_q};
  assign rd_index = (rd_sum >= NUM_CELLS_EXT) ? CELL_W'(rd_sum - NUM_CELLS_EXT)
                                              : rd_sum[CELL_W-1:0];
`else
  assign rd_index = cell_q;
`endif

  always_comb begin
    active_d = active_q;
    px_cnt_d = px_cnt_q;
    cell_d   = cell_q;
    x_acc_d  = x_acc_q;
    if (start_hit) begin
      active_d = 1'b1;
      px_cnt_d = '0;
      cell_d   = '0;
      x_acc_d  = X_START;
    end else if (active_q) begin
      // A jump in hcount (line wrap, retrace) ends the run until the next start hit.
      if (!h_contig) begin
        active_d = 1'b0;
      end else if (px_cnt_q == PX_LAST) begin
        px_cnt_d = '0;
        if (cell_q == CELL_LAST) begin
          active_d = 1'b0;
        end else begin
          cell_d  = cell_q + CELL_W'(1);
          x_acc_d = x_acc_q + X_STEP;
        end
      end else begin
        px_cnt_d = px_cnt_q + PX_W'(1);
      end
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      active_q <= 1'b0;
      px_cnt_q <= '0;
      cell_q   <= '0;
      x_acc_q  <= '0;
      h1_q     <= '0;
      v1_q     <= '0;
    end else begin
      active_q <= active_d;
      px_cnt_q <= px_cnt_d;
      cell_q   <= cell_d;
      x_acc_q  <= x_acc_d;
      h1_q     <= hcount_in;
      v1_q     <= vcount_in;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      select_letter_out <= BLANK_CODE;
      x_out             <= '0;
      y_out             <= '0;
      cell_active_out   <= 1'b0;
      hcount_out        <= '0;
      vcount_out        <= '0;
    end else begin
      select_letter_out <= active_q ? rd_code : BLANK_CODE;
      x_out             <= active_q ? x_acc_q : '0;
      y_out             <= active_q ? Y_TOP : '0;
      cell_active_out   <= active_q;
      hcount_out        <= h1_q;
      vcount_out        <= v1_q;
    end
  end

endmodule

// File: tb/tb_letter_cell_sequencer.sv
// Directed bench for letter_cell_sequencer (default build, LETTER_SCROLL_EN undefined).
module tb_letter_cell_sequencer;
  import letter_pkg::*;

  logic         pixel_clk_in = 1'b0;
  logic         rst_in;
  logic [10:0]  hcount_in;
  logic [9:0]   vcount_in;
  logic         wr_valid_in;
  logic         wr_ready_out;
  logic [2:0]   wr_index_in;
  logic [5:0]   wr_code_in;
  logic [5:0]   select_letter_out;
  logic [10:0]  x_out;
  logic [9:0]   y_out;
  logic         cell_active_out;
  logic [10:0]  hcount_out;
  logic [9:0]   vcount_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0]  sel_a [0:1023];
  logic [10:0] x_a   [0:1023];
  logic        act_a [0:1023];

  always #5 pixel_clk_in = ~pixel_clk_in;

  letter_cell_sequencer dut (
    .pixel_clk_in      (pixel_clk_in),
    .rst_in            (rst_in),
    .hcount_in         (hcount_in),
    .vcount_in         (vcount_in),
    .wr_valid_in       (wr_valid_in),
    .wr_ready_out      (wr_ready_out),
    .wr_index_in       (wr_index_in),
    .wr_code_in        (wr_code_in),
    .select_letter_out (select_letter_out),
    .x_out             (x_out),
    .y_out             (y_out),
    .cell_active_out   (cell_active_out),
    .hcount_out        (hcount_out),
    .vcount_out        (vcount_out)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int h, input int v);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    @(posedge pixel_clk_in);
    #1;
  endtask

  // After step(h) the outputs describe the pixel presented one cycle earlier.
  task automatic sweep(input int v);
    for (int h = 0; h <= 1024; h++) begin
      step(h, v);
      if (h >= 1) begin
        sel_a[h-1] = select_letter_out;
        x_a[h-1]   = x_out;
        act_a[h-1] = cell_active_out;
      end
    end
  endtask

  task automatic write_cell(input int idx, input int code, input int v);
    wr_valid_in = 1'b1;
    wr_index_in = 3'(idx);
    wr_code_in  = 6'(code);
    step(5, v);
    wr_valid_in = 1'b0;
  endtask

  task automatic count_line(output int n_act, output int n_nonblank);
    n_act = 0;
    n_nonblank = 0;
    for (int p = 0; p < 1024; p++) begin
      if (act_a[p]) n_act++;
      if (sel_a[p] != 6'd63) n_nonblank++;
    end
  endtask

  initial begin
    int na, nb;
    rst_in      = 1'b0;
    hcount_in   = 11'd5;
    vcount_in   = 10'd5;
    wr_valid_in = 1'b0;
    wr_index_in = '0;
    wr_code_in  = '0;
    #12;
    check("rst_sel",    select_letter_out, 63);
    check("rst_x",      x_out, 0);
    check("rst_y",      y_out, 0);
    check("rst_active", cell_active_out, 0);
    check("rst_hout",   hcount_out, 0);
    check("rst_ready",  wr_ready_out, 0);

    @(negedge pixel_clk_in);
    rst_in = 1'b1;
    step(5, 5);
    check("ready_idle", wr_ready_out, 1);

    for (int i = 0; i < 8; i++) write_cell(i, i + 1, 5);
    step(0, 0);

    sweep(256);
    check("h16_sel",    sel_a[16], 1);
    check("h16_x",      x_a[16], 16);
    check("h16_active", act_a[16], 1);
    check("h15_active", act_a[15], 0);
    check("h134_sel",   sel_a[134], 1);
    check("h135_sel",   sel_a[135], 2);
    check("h135_x",     x_a[135], 135);
    check("h967_sel",   sel_a[967], 8);
    check("h967_x",     x_a[967], 849);
    check("h968_active", act_a[968], 0);
    check("h968_sel",   sel_a[968], 63);
    check("h968_x",     x_a[968], 0);
    check("hout_delay", hcount_out, 1023);
    check("vout_delay", vcount_out, 256);

    sweep(255);
    count_line(na, nb);
    check("v255_active", na, 0);
    check("v255_code",   nb, 0);
    sweep(337);
    check("v337_active", act_a[16], 1);
    sweep(338);
    count_line(na, nb);
    check("v338_active", na, 0);
    check("v338_code",   nb, 0);

    write_cell(3, 20, 300);
    sweep(256);
    check("midframe_old", sel_a[373], 4);
    step(0, 0);
    sweep(256);
    check("midframe_new", sel_a[373], 20);

    wr_valid_in = 1'b1;
    wr_index_in = 3'd5;
    wr_code_in  = 6'd33;
    hcount_in   = 11'd0;
    vcount_in   = 10'd0;
    #1;
    check("commit_ready", wr_ready_out, 0);
    @(posedge pixel_clk_in);
    #1;
    hcount_in = 11'd1;
    #1;
    check("post_commit_ready", wr_ready_out, 1);
    @(posedge pixel_clk_in);
    #1;
    wr_valid_in = 1'b0;
    sweep(256);
    check("late_write_hidden", sel_a[611], 6);
    step(0, 0);
    sweep(256);
    check("late_write_shown", sel_a[611], 33);

    for (int h = 0; h <= 200; h++) step(h, 256);
    check("pre_jump_active", cell_active_out, 1);
    step(500, 256);
    step(501, 256);
    check("jump_active", cell_active_out, 0);
    check("jump_sel",    select_letter_out, 63);

    for (int h = 0; h <= 400; h++) step(h, 256);
    check("pre_rst_active", cell_active_out, 1);
    rst_in = 1'b0;
    #1;
    check("midrst_active", cell_active_out, 0);
    check("midrst_sel",    select_letter_out, 63);
    check("midrst_x",      x_out, 0);
    check("midrst_y",      y_out, 0);
    check("midrst_ready",  wr_ready_out, 0);
    @(posedge pixel_clk_in);
    @(posedge pixel_clk_in);
    #1;
    rst_in = 1'b1;
    sweep(257);
    check("resume_active", act_a[16], 1);
    check("resume_x",      x_a[16], 16);
    check("resume_sel",    sel_a[16], 63);
    check("resume_end",    act_a[968], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
